ap_seq_ctrl: RTL and testbench

// Sequencer for the CAM associative-processor array. Idle: passes host single-word read/write to the CAM (cam_mode=0).

---
 rtl/ap_pkg.sv | 44 ++++
 rtl/ap_pass_rom.sv | 55 +++++
 rtl/ap_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ap_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ap_pkg
// Description : Shared types, op codes, ADD pass table and sizing helpers for
//               the CAM associative-processor sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ap_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH     = 2'b00,
        OP_MATCHWRITE = 2'b01,
        OP_ADD        = 2'b10,
        OP_RSVD       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMP  = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3
    } state_e;

    localparam logic [2:0] PASS_PRE  = 3'd4;
    localparam logic [2:0] PASS_LAST = 3'd3;

    // Entry = {match C,A,B ; write C,B}; order chosen so no word re-matches a later pass.
    localparam logic [3:0][4:0] ADD_PASS_TABLE = {5'b010_01, 5'b101_10, 5'b100_01, 5'b011_10};

    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int field_f(input int ws);
        return (ws - 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_pass_rom.sv
`default_nettype none
// ============================================================================
// Module      : ap_pass_rom
// Description : Combinational compare/write pattern generator for ADD passes.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_pass_rom
    import ap_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int BW        = 2
) (
    input  op_e                  op,
    input  logic [BW-1:0]        bit_idx,
    input  logic [2:0]           pass_idx,
    output logic [WORD_SIZE-1:0] key,
    output logic [WORD_SIZE-1:0] cmp_mask,
    output logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] wr_mask,
    output logic                 last
);

    localparam int            F        = field_f(WORD_SIZE);
    localparam logic [BW-1:0] LAST_BIT = BW'(F - 1);

    logic [WORD_SIZE-1:0] c_bit;
    logic [WORD_SIZE-1:0] a_bit;
    logic [WORD_SIZE-1:0] b_bit;
    logic [4:0]           entry;

    always_comb begin
        c_bit    = {1'b1, {(WORD_SIZE-1){1'b0}}};
        a_bit    = {{(WORD_SIZE-1){1'b0}}, 1'b1} << bit_idx;
        b_bit    = a_bit << F;
        entry    = ADD_PASS_TABLE[pass_idx[1:0]];
        key      = '0;
        cmp_mask = '0;
        wdata    = '0;
        wr_mask  = '0;
        last     = 1'b1;
        if (op == OP_ADD) begin
            last    = (bit_idx == LAST_BIT) && (pass_idx == PASS_LAST);
            wr_mask = c_bit;
            // The pre-pass keeps an all-zero compare so every word clears its carry.
            if (pass_idx != PASS_PRE) begin
                key      = (entry[4] ? c_bit : '0) | (entry[3] ? a_bit : '0) | (entry[2] ? b_bit : '0);
                cmp_mask = c_bit | a_bit | b_bit;
                wdata    = (entry[1] ? c_bit : '0) | (entry[0] ? b_bit : '0);
                wr_mask  = c_bit | b_bit;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ap_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ap_seq_ctrl
// Description : CAM associative-processor sequencer: host passthrough when idle,
//               compare/write pass sequences for SEARCH, MATCHWRITE and ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_seq_ctrl
    import ap_pkg::*;
#(
    parameter  int WORD_SIZE  = 8,
    parameter  int CELL_QUANT = 512,
    localparam int AW         = clogb2(CELL_QUANT)
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WORD_SIZE-1:0]  op_key,
    input  logic [WORD_SIZE-1:0]  op_mask,
    input  logic [WORD_SIZE-1:0]  op_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  hit,
    output logic [CELL_QUANT-1:0] result_tags,
    input  logic [AW-1:0]         host_addr,
    input  logic [WORD_SIZE-1:0]  host_din,
    input  logic                  host_we,
    output logic [WORD_SIZE-1:0]  host_dout,
    output logic [AW-1:0]         cam_addr_in,
    output logic                  cam_mode,
    output logic                  cam_wea,
    output logic [WORD_SIZE-1:0]  cam_dina,
    output logic [WORD_SIZE-1:0]  cam_key_v,
    output logic [WORD_SIZE-1:0]  cam_mask_v,
    output logic [CELL_QUANT-1:0] cam_wea_ap,
    output logic                  cam_direction,
    input  logic [CELL_QUANT-1:0] cam_tags,
    input  logic [WORD_SIZE-1:0]  cam_doutb
);

    localparam int F  = field_f(WORD_SIZE);
    localparam int BW = (F > 1) ? clogb2(F) : 1;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [WORD_SIZE-1:0]  key_q, key_d;
    logic [WORD_SIZE-1:0]  mask_q, mask_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            pass_q, pass_d;
    logic [CELL_QUANT-1:0] tag_q, tag_d;
    logic [CELL_QUANT-1:0] result_tags_q, result_tags_d;
    logic                  hit_q, hit_d;

    logic [WORD_SIZE-1:0]  rom_key, rom_cmp_mask, rom_wdata, rom_wr_mask;
    logic                  rom_last;
    logic [WORD_SIZE-1:0]  pass_key, pass_cmp_mask, pass_wdata, pass_wr_mask;

    ap_pass_rom #(
        .WORD_SIZE (WORD_SIZE),
        .BW        (BW)
    ) u_pass_rom (
        .op       (op_q),
        .bit_idx  (bit_q),
        .pass_idx (pass_q),
        .key      (rom_key),
        .cmp_mask (rom_cmp_mask),
        .wdata    (rom_wdata),
        .wr_mask  (rom_wr_mask),
        .last     (rom_last)
    );

    always_comb begin
        pass_key      = key_q;
        pass_cmp_mask = mask_q;
        pass_wdata    = wdata_q;
        pass_wr_mask  = mask_q;
        if (op_q == OP_ADD) begin
            pass_key      = rom_key;
            pass_cmp_mask = rom_cmp_mask;
            pass_wdata    = rom_wdata;
            pass_wr_mask  = rom_wr_mask;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        key_d         = key_q;
        mask_d        = mask_q;
        wdata_d       = wdata_q;
        bit_d         = bit_q;
        pass_d        = pass_q;
        tag_d         = tag_q;
        result_tags_d = result_tags_q;
        hit_d         = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    key_d   = op_key;
                    mask_d  = op_mask;
                    wdata_d = op_wdata;
                    bit_d   = '0;
                    pass_d  = (op_e'(op) == OP_ADD) ? PASS_PRE : 3'd0;
                    state_d = (op_e'(op) == OP_RSVD) ? ST_DONE : ST_CMP;
                end
            end
            ST_CMP: begin
                tag_d = cam_tags;
                if (op_q == OP_SEARCH) begin
                    result_tags_d = cam_tags;
                    hit_d         = |cam_tags;
                    state_d       = ST_DONE;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (rom_last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CMP;
                    if (pass_q == PASS_PRE) begin
                        pass_d = 3'd0;
                    end else if (pass_q == PASS_LAST) begin
                        pass_d = 3'd0;
                        bit_d  = bit_q + BW'(1);
                    end else begin
                        pass_d = pass_q + 3'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_SEARCH;
            key_q         <= '0;
            mask_q        <= '0;
            wdata_q       <= '0;
            bit_q         <= '0;
            pass_q        <= '0;
            tag_q         <= '0;
            result_tags_q <= '0;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            key_q         <= key_d;
            mask_q        <= mask_d;
            wdata_q       <= wdata_d;
            bit_q         <= bit_d;
            pass_q        <= pass_d;
            tag_q         <= tag_d;
            result_tags_q <= result_tags_d;
            hit_q         <= hit_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_DONE) && (op_q == OP_RSVD);
    assign hit           = hit_q;
    assign result_tags   = result_tags_q;
    assign host_dout     = cam_doutb;
    assign cam_addr_in   = (state_q == ST_IDLE) ? host_addr : '0;
    assign cam_mode      = (state_q == ST_WR);
    // Host writes only reach the CAM while idle, so they never collide with a parallel write.
    assign cam_wea       = host_we & ~busy;
    assign cam_dina      = (state_q == ST_IDLE) ? host_din : ((state_q == ST_WR) ? pass_wdata : '0);
    assign cam_key_v     = (state_q == ST_CMP) ? pass_key : '0;
    assign cam_mask_v    = (state_q == ST_CMP) ? pass_cmp_mask : ((state_q == ST_WR) ? pass_wr_mask : '0);
    assign cam_wea_ap    = (state_q == ST_WR) ? tag_q : '0;
    assign cam_direction = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ap_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_seq_ctrl
// Description : Scoreboard bench for ap_seq_ctrl with a behavioural CAM array
//               and an arithmetic reference model of SEARCH/MATCHWRITE/ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_seq_ctrl;
    import ap_pkg::*;

    localparam int WS = 8;
    localparam int CQ = 512;
    localparam int AW = 9;
    localparam int F  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [WS-1:0] op_key, op_mask, op_wdata;
    logic          busy, done, err, hit;
    logic [CQ-1:0] result_tags;
    logic [AW-1:0] host_addr;
    logic [WS-1:0] host_din;
    logic          host_we;
    logic [WS-1:0] host_dout;
    logic [AW-1:0] cam_addr_in;
    logic          cam_mode, cam_wea;
    logic [WS-1:0] cam_dina, cam_key_v, cam_mask_v;
    logic [CQ-1:0] cam_wea_ap;
    logic          cam_direction;
    logic [CQ-1:0] cam_tags;
    logic [WS-1:0] cam_doutb;

    ap_seq_ctrl #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ(clk), .rst(rst_n), .start(start), .op(op),
        .op_key(op_key), .op_mask(op_mask), .op_wdata(op_wdata),
        .busy(busy), .done(done), .err(err), .hit(hit), .result_tags(result_tags),
        .host_addr(host_addr), .host_din(host_din), .host_we(host_we), .host_dout(host_dout),
        .cam_addr_in(cam_addr_in), .cam_mode(cam_mode), .cam_wea(cam_wea), .cam_dina(cam_dina),
        .cam_key_v(cam_key_v), .cam_mask_v(cam_mask_v), .cam_wea_ap(cam_wea_ap),
        .cam_direction(cam_direction), .cam_tags(cam_tags), .cam_doutb(cam_doutb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CAM: mask bit 1 means compare (CMP) or write (WR) that bit.
    logic [CQ-1:0][WS-1:0] cam_mem;
    always_comb begin
        cam_tags = '0;
        for (int i = 0; i < CQ; i++) cam_tags[i] = (((cam_mem[i] ^ cam_key_v) & cam_mask_v) == '0);
    end
    assign cam_doutb = cam_mem[cam_addr_in];
    always @(posedge clk) begin
        if (cam_mode) begin
            for (int i = 0; i < CQ; i++)
                if (cam_wea_ap[i]) cam_mem[i] <= (cam_mem[i] & ~cam_mask_v) | (cam_dina & cam_mask_v);
        end else if (cam_wea) begin
            cam_mem[cam_addr_in] <= cam_dina;
        end
    end

    logic [CQ-1:0][WS-1:0] ref_mem;

    typedef struct {
        logic [1:0]            op;
        int                    issue;
        int                    lat;
        logic                  hit;
        logic [CQ-1:0]         tags;
        logic [CQ-1:0][WS-1:0] mem;
    } exp_t;

    exp_t sb_q[$];
    exp_t got_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input bit ok, input string msg);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    function automatic logic [WS-1:0] add_word(input logic [WS-1:0] w);
        logic [F-1:0]  a, b;
        logic [F:0]    s;
        logic [WS-1:0] r;
        a = w[F-1:0];
        b = w[2*F-1:F];
        s = {1'b0, a} + {1'b0, b};
        r = w;
        r[2*F-1:F] = s[F-1:0];
        r[WS-1]    = s[F];
        return r;
    endfunction

    // Monitor: pops one expectation for every done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1'b0, "done asserted with no pending op");
            end else begin
                int bad;
                string s;
                got_e = sb_q.pop_front();
                chk("latency", (cyc - got_e.issue) == got_e.lat,
                    $sformatf("op %0d got %0d cycles expected %0d", got_e.op, cyc - got_e.issue, got_e.lat));
                chk("err", err === (got_e.op == 2'b11),
                    $sformatf("op %0d got %b expected %b", got_e.op, err, got_e.op == 2'b11));
                if (got_e.op == 2'b00) begin
                    chk("hit", hit === got_e.hit, $sformatf("got %b expected %b", hit, got_e.hit));
                    chk("result_tags", result_tags === got_e.tags,
                        $sformatf("got %h expected %h", result_tags, got_e.tags));
                end
                bad = -1;
                for (int i = 0; i < CQ; i++)
                    if (bad < 0 && cam_mem[i] !== got_e.mem[i]) bad = i;
                s = "";
                if (bad >= 0)
                    s = $sformatf("op %0d word %0d got %h expected %h", got_e.op, bad, cam_mem[bad], got_e.mem[bad]);
                chk("cam_contents", bad < 0, s);
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [WS-1:0] d);
        @(negedge clk);
        host_addr  = a;
        host_din   = d;
        host_we    = 1'b1;
        ref_mem[a] = d;
    endtask

    task automatic host_idle();
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic fill_random();
        logic [WS-1:0] d;
        for (int i = 0; i < CQ; i++) begin
            d = WS'($urandom);
            if (d == 8'h3C) d = 8'h3D;
            host_write(AW'(i), d);
        end
        host_idle();
    endtask

    // noisy: 0 quiet, 1 random start/op/host noise while busy, 2 same with host writes aimed at word 7
    task automatic do_op(input logic [1:0] o, input logic [WS-1:0] k, input logic [WS-1:0] m,
                         input logic [WS-1:0] w, input int noisy);
        exp_t e;
        int   n;
        @(negedge clk);
        e.op    = o;
        e.issue = cyc;
        e.tags  = '0;
        e.hit   = 1'b0;
        case (o)
            2'b00: begin
                for (int i = 0; i < CQ; i++) e.tags[i] = (((ref_mem[i] ^ k) & m) == '0);
                e.hit = |e.tags;
                e.lat = 2;
            end
            2'b01: begin
                for (int i = 0; i < CQ; i++)
                    if (((ref_mem[i] ^ k) & m) == '0) ref_mem[i] = (ref_mem[i] & ~m) | (w & m);
                e.lat = 3;
            end
            2'b10: begin
                for (int i = 0; i < CQ; i++) ref_mem[i] = add_word(ref_mem[i]);
                e.lat = 2 + 8 * F + 1;
            end
            default: e.lat = 1;
        endcase
        e.mem = ref_mem;
        sb_q.push_back(e);
        start    = 1'b1;
        op       = o;
        op_key   = k;
        op_mask  = m;
        op_wdata = w;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy) break;
            if (noisy != 0) begin
                start     = 1'($urandom);
                op        = 2'($urandom);
                op_key    = WS'($urandom);
                op_mask   = WS'($urandom);
                op_wdata  = WS'($urandom);
                host_we   = 1'($urandom);
                host_addr = (noisy == 2) ? AW'(7) : AW'($urandom_range(0, CQ - 1));
                host_din  = WS'($urandom);
            end
        end
        start   = 1'b0;
        host_we = 1'b0;
        chk("op_timeout", n < 200, $sformatf("op %0d still busy after %0d cycles", o, n));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CQ-1:0]         want;
        logic [CQ-1:0][WS-1:0] snap;
        int                    idx;
        rst_n = 1'b0; start = 1'b1; op = 2'b10;
        op_key = 8'hFF; op_mask = 8'hFF; op_wdata = 8'h00;
        host_we = 1'b0; host_addr = '0; host_din = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, err, hit, cam_mode, cam_wea, cam_direction} === 7'b0,
            $sformatf("got %b expected 0000000", {busy, done, err, hit, cam_mode, cam_wea, cam_direction}));
        chk("reset_vectors", result_tags === '0 && cam_wea_ap === '0,
            $sformatf("result_tags %h cam_wea_ap %h expected all zero", result_tags, cam_wea_ap));
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", busy === 1'b0, $sformatf("busy got %b expected 0", busy));

        fill_random();
        host_write(AW'(5), 8'h3C);
        host_write(AW'(9), 8'h3C);
        host_idle();
        host_addr = AW'(5);
        #1;
        chk("host_readback", host_dout === 8'h3C, $sformatf("got %h expected 3c", host_dout));
        host_addr = AW'(123);
        #1;
        chk("host_read_rand", host_dout === ref_mem[123], $sformatf("got %h expected %h", host_dout, ref_mem[123]));

        do_op(2'b00, 8'h3C, 8'hFF, 8'h00, 0);
        want = '0; want[5] = 1'b1; want[9] = 1'b1;
        chk("search_5_9", result_tags === want && hit === 1'b1,
            $sformatf("tags %h hit %b expected %h hit 1", result_tags, hit, want));

        host_write(AW'(30), 8'hA0);
        host_write(AW'(31), 8'hA1);
        host_idle();
        do_op(2'b01, 8'h00, 8'h0F, 8'h05, 1);
        chk("mw_word30", cam_mem[30] === 8'hA5, $sformatf("got %h expected a5", cam_mem[30]));
        chk("mw_word31", cam_mem[31] === 8'hA1, $sformatf("got %h expected a1", cam_mem[31]));

        host_write(AW'(20), 8'h33);
        host_write(AW'(21), 8'h0A);
        host_idle();
        do_op(2'b10, 8'h00, 8'h00, 8'h00, 2);
        chk("add_3_6", cam_mem[20] === 8'h8B, $sformatf("got %h expected 8b", cam_mem[20]));
        chk("add_2_1", cam_mem[21] === 8'h1A, $sformatf("got %h expected 1a", cam_mem[21]));
        chk("add_busy_hostwe", cam_mem[7] === ref_mem[7], $sformatf("got %h expected %h", cam_mem[7], ref_mem[7]));

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                host_write(AW'($urandom_range(0, CQ - 1)), WS'($urandom));
                host_write(AW'($urandom_range(0, CQ - 1)), WS'($urandom));
                host_idle();
            end
            idx = $urandom_range(0, CQ - 1);
            do_op(2'($urandom_range(0, 3)), ref_mem[idx], WS'($urandom), WS'($urandom), 1);
        end

        @(negedge clk);
        start = 1'b1; op = 2'b10;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", busy === 1'b0 && cam_wea_ap === '0 && cam_mode === 1'b0,
            $sformatf("busy %b cam_mode %b wea_ap_nonzero %b expected 0 0 0", busy, cam_mode, |cam_wea_ap));
        snap = cam_mem;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write", cam_mem === snap, "CAM contents changed while held in reset");
        @(negedge clk); rst_n = 1'b1;

        fill_random();
        do_op(2'b11, 8'h00, 8'h00, 8'hFF, 0);
        @(negedge clk);
        chk("err_pulse_end", err === 1'b0 && done === 1'b0, $sformatf("err %b done %b expected 0 0", err, done));

        for (int t = 0; t < 10; t++) begin
            idx = $urandom_range(0, CQ - 1);
            do_op(2'($urandom_range(0, 3)), ref_mem[idx], WS'($urandom), WS'($urandom), 1);
        end

        @(negedge clk);
        chk("scoreboard_drained", sb_q.size() == 0, $sformatf("%0d ops never completed", sb_q.size()));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
